// File: rtl/fifo_uart_tx.sv
`timescale 1ns/1ps
// fifo_uart_tx: pops words from an upstream FIFO and sends each as a UART frame (start, data LSB first, optional even parity, stop)
// Latency: fifo_rd_en rises one cycle after IDLE sees enable & !fifo_empty; the start bit begins two cycles after FETCH entry
// Backpressure: a frame starts only when enable=1 and the FIFO is non-empty; a frame in flight always runs to completion
// Ports: clk, rst (async, active-high), enable, fifo_empty, fifo_data[DATA_WIDTH-1:0] in;
//        fifo_rd_en, tx, busy, frame_done out (all driven straight from flops)
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] IDX_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [BW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  rd_en_q, rd_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        parity_d = parity_q;

        case (state_q)
            S_IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // FIFO read data is registered, so it is valid in the cycle after FETCH
                shift_d  = fifo_data;
                parity_d = ^fifo_data;
                timer_d  = BIT_LAST;
                idx_d    = '0;
                state_d  = S_START;
            end
            S_START: begin
                if (timer_q == '0) begin
                    timer_d = BIT_LAST;
                    state_d = S_DATA;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_DATA: begin
                if (timer_q == '0) begin
                    timer_d = BIT_LAST;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_PARITY: begin
                if (timer_q == '0) begin
                    timer_d = BIT_LAST;
                    state_d = S_STOP;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_STOP: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
                idx_d   = '0;
            end
        endcase

        // Outputs are computed from the next state so the flops line up with the state they describe
        rd_en_d = (state_d == S_FETCH);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_STOP) && (timer_d == '0);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            rd_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            rd_en_q  <= rd_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
`timescale 1ns/1ps
// tb_fifo_uart_tx: two transmitters (no parity / even parity) fed from one byte stream through per-lane FIFO models
// Latency: expected waveform derived per frame from the byte value; checked every falling edge
// Backpressure: enable toggled by the stimulus; fetches are checked against the enable seen by the DUT
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] fifo_empty;
    logic [1:0] fifo_rd_en;
    logic [1:0] tx;
    logic [1:0] busy;
    logic [1:0] frame_done;
    logic [7:0] fdata0 = 8'h00;
    logic [7:0] fdata1 = 8'h00;

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) u_dut0 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty[0]), .fifo_data(fdata0),
        .fifo_rd_en(fifo_rd_en[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(frame_done[0])
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty[1]), .fifo_data(fdata1),
        .fifo_rd_en(fifo_rd_en[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(frame_done[1])
    );

    // Byte stream shared by both lanes; each lane has its own FIFO read pointer
    logic [7:0] stim_mem [256];
    int wr_ptr  = 0;
    int rd_ptr0 = 0;
    int rd_ptr1 = 0;

    assign fifo_empty[0] = (rd_ptr0 == wr_ptr);
    assign fifo_empty[1] = (rd_ptr1 == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en[0] && rd_ptr0 != wr_ptr) begin
            fdata0  <= stim_mem[rd_ptr0];
            rd_ptr0 <= rd_ptr0 + 1;
        end
        if (fifo_rd_en[1] && rd_ptr1 != wr_ptr) begin
            fdata1  <= stim_mem[rd_ptr1];
            rd_ptr1 <= rd_ptr1 + 1;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    int         n_chk  = 0;
    int         n_fail = 0;
    int         k       [2];
    int         gap     [2];
    int         mon_ptr [2];
    logic [7:0] cur     [2];
    logic       en_prev = 1'b0;
    logic       end_req = 1'b0;
    logic       end_ack = 1'b0;

    task automatic chk(input string nm, input int lane, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s lane%0d t=%0t: got %0h expected %0h", nm, lane, $time, act, exp);
        end
    endtask

    // Line level expected kk cycles after FETCH entry: FETCH and LOAD idle high, then
    // start bit, 8 data bits LSB first, optional even parity, stop bit, each CPB cycles
    function automatic logic exp_tx(input logic [7:0] d, input int par, input int kk);
        int b;
        if (kk < 2) return 1'b1;
        b = (kk - 2) / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (par != 0 && b == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic step(input int i);
        int flen;
        flen = 2 + (10 + i) * CPB;
        if (k[i] < 0) begin
            if (fifo_rd_en[i] && gap[i] == 0) begin
                chk("fetch_with_enable", i, en_prev, 1);
                chk("fetch_fifo_nonempty", i, (i == 0) ? (rd_ptr0 != wr_ptr) : (rd_ptr1 != wr_ptr), 1);
                cur[i]     = stim_mem[mon_ptr[i]];
                mon_ptr[i] = mon_ptr[i] + 1;
                chk("fetch_tx", i, tx[i], 1);
                chk("fetch_busy", i, busy[i], 1);
                chk("fetch_done", i, frame_done[i], 0);
                k[i] = 1;
            end else begin
                chk("idle_tx", i, tx[i], 1);
                chk("idle_busy", i, busy[i], 0);
                chk("idle_done", i, frame_done[i], 0);
                chk("idle_rd_en", i, fifo_rd_en[i], 0);
                gap[i] = 0;
            end
        end else begin
            chk("frame_tx", i, tx[i], exp_tx(cur[i], i, k[i]));
            chk("frame_done", i, frame_done[i], (k[i] == flen - 1));
            chk("frame_busy", i, busy[i], 1);
            chk("frame_rd_en", i, fifo_rd_en[i], 0);
            k[i] = k[i] + 1;
            if (k[i] == flen) begin
                k[i]   = -1;
                gap[i] = 1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            k[i]       = -1;
            gap[i]     = 0;
            mon_ptr[i] = 0;
            cur[i]     = 8'h00;
        end
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                #1;
                for (int i = 0; i < 2; i++) begin
                    chk("rst_tx", i, tx[i], 1);
                    chk("rst_busy", i, busy[i], 0);
                    chk("rst_done", i, frame_done[i], 0);
                    chk("rst_rd_en", i, fifo_rd_en[i], 0);
                    k[i]   = -1;
                    gap[i] = 0;
                end
            end else begin
                for (int i = 0; i < 2; i++) step(i);
                if (end_req && !end_ack) begin
                    for (int i = 0; i < 2; i++) begin
                        chk("all_bytes_sent", i, mon_ptr[i], wr_ptr);
                        chk("ends_idle", i, (k[i] < 0), 1);
                    end
                    end_ack = 1'b1;
                end
            end
            en_prev = enable;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] b);
        stim_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        cycles(3);
        rst = 1'b0;
        cycles(2);

        // Single frames: 0xA5 (parity 0) and 0x07 (parity 1)
        enable = 1'b1;
        push(8'hA5);
        cycles(60);
        push(8'h07);
        cycles(60);

        // Back-to-back frames with enable held high
        push(8'h01);
        push(8'h02);
        push(8'h03);
        cycles(170);

        // Empty FIFO with enable high: line must stay idle
        cycles(100);

        // Enable dropped in DATA of frame 1 with a second byte queued
        push(8'h3C);
        push(8'hC3);
        cycles(15);
        enable = 1'b0;
        cycles(150);
        enable = 1'b1;
        cycles(120);

        // Asynchronous reset in the middle of DATA, then a clean frame
        push(8'h5A);
        cycles(20);
        #1;
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        push(8'h96);
        cycles(60);

        // Random bytes with random gaps and enable toggling
        for (int n = 0; n < 20; n++) begin
            push(8'($urandom_range(0, 255)));
            cycles($urandom_range(1, 60));
            enable = ($urandom_range(0, 3) != 0);
        end
        enable = 1'b1;
        cycles(20 * 50 + 100);

        end_req = 1'b1;
        for (int c = 0; c < 20 && !end_ack; c++) @(posedge clk);
        if (!end_ack) begin
            $display("FAIL end_handshake: monitor did not complete final checks");
            $fatal(1, "monitor stalled");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
